// File: rtl/addr_map_decode_pipe.sv
// -----------------------------------------------------------------------------
// addr_map_decode_pipe
//
// Registered address decoder that sits behind the address-map rule table.
// Each accepted request address is compared against NUM_RULES rules
// (start_addr <= addr < end_addr, unsigned). The lowest matching array
// position wins. The decoded slave index is emitted one cycle later, or
// DEFAULT_IDX together with an error flag when nothing matches. A skid slot
// behind the output register keeps one transfer per cycle under
// backpressure while in_ready_o stays a pure flop output.
//
// Optional feature macro: ADDR_MAP_DECODE_MISS_STATS_EN
//   defined   : saturating miss counter plus the address of the latest miss,
//               both updated when a request is accepted.
//   undefined : miss_cnt_o / last_miss_addr_o are tied to zero.
//
// Ports
//   clk_i             clock
//   rst_ni            asynchronous active-low reset
//   addr_map_i        rule table, held stable while requests are in flight
//   in_valid_i        request valid
//   in_ready_o        request accepted when high together with in_valid_i
//   in_addr_i         request address
//   out_valid_o       decoded result valid
//   out_ready_i       consumer ready
//   out_addr_o        request address passed through
//   out_idx_o         idx field of the matching rule, or DEFAULT_IDX
//   out_err_o         high when no rule matched
//   miss_cnt_o        saturating count of accepted misses (optional feature)
//   last_miss_addr_o  address of the latest accepted miss (optional feature)
// -----------------------------------------------------------------------------
package addr_map_rule_pkg;
    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_map_rule_t;
endpackage

module addr_map_decode_pipe #(
    parameter int unsigned NUM_RULES   = 4,
    parameter logic [31:0] DEFAULT_IDX = 32'd0
) (
    input  logic                                             clk_i,
    input  logic                                             rst_ni,
    input  addr_map_rule_pkg::addr_map_rule_t [NUM_RULES-1:0] addr_map_i,
    input  logic                                             in_valid_i,
    output logic                                             in_ready_o,
    input  logic [31:0]                                      in_addr_i,
    output logic                                             out_valid_o,
    input  logic                                             out_ready_i,
    output logic [31:0]                                      out_addr_o,
    output logic [31:0]                                      out_idx_o,
    output logic                                             out_err_o,
    output logic [15:0]                                      miss_cnt_o,
    output logic [31:0]                                      last_miss_addr_o
);

    // ---- stage p0: combinational decode of the incoming address ----
    logic        dec_hit_p0;
    logic [31:0] dec_idx_p0;

    // Walk from the highest position down so the lowest matching position
    // overwrites last and therefore wins. start >= end can never satisfy both
    // compares, so empty/inverted rules drop out naturally.
    always_comb begin
        dec_hit_p0 = 1'b0;
        dec_idx_p0 = DEFAULT_IDX;
        for (int i = int'(NUM_RULES) - 1; i >= 0; i--) begin
            if ((in_addr_i >= addr_map_i[i].start_addr) &&
                (in_addr_i <  addr_map_i[i].end_addr)) begin
                dec_hit_p0 = 1'b1;
                dec_idx_p0 = addr_map_i[i].idx;
            end
        end
    end

    // ---- stage p1: output register (OR) and skid register (SK) ----
    logic        out_vld_q,  out_vld_d;
    logic [31:0] out_addr_q, out_addr_d;
    logic [31:0] out_idx_q,  out_idx_d;
    logic        out_err_q,  out_err_d;
    logic        sk_vld_q,   sk_vld_d;
    logic [31:0] sk_addr_q,  sk_addr_d;
    logic [31:0] sk_idx_q,   sk_idx_d;
    logic        sk_err_q,   sk_err_d;
    logic        in_rdy_q,   in_rdy_d;

    logic in_xfer;
    logic out_drain;

    assign in_xfer   = in_valid_i && in_rdy_q;
    assign out_drain = out_vld_q && out_ready_i;

    always_comb begin
        out_vld_d  = out_vld_q;
        out_addr_d = out_addr_q;
        out_idx_d  = out_idx_q;
        out_err_d  = out_err_q;
        sk_vld_d   = sk_vld_q;
        sk_addr_d  = sk_addr_q;
        sk_idx_d   = sk_idx_q;
        sk_err_d   = sk_err_q;

        if (!out_vld_q || out_drain) begin
            // OR is free this edge: the skid entry is older, so it goes first.
            // in_ready is low whenever SK is full, so no input is lost here.
            if (sk_vld_q) begin
                out_vld_d  = 1'b1;
                out_addr_d = sk_addr_q;
                out_idx_d  = sk_idx_q;
                out_err_d  = sk_err_q;
                sk_vld_d   = 1'b0;
            end else if (in_xfer) begin
                out_vld_d  = 1'b1;
                out_addr_d = in_addr_i;
                out_idx_d  = dec_idx_p0;
                out_err_d  = !dec_hit_p0;
            end else begin
                out_vld_d  = 1'b0;
            end
        end else if (in_xfer) begin
            sk_vld_d  = 1'b1;
            sk_addr_d = in_addr_i;
            sk_idx_d  = dec_idx_p0;
            sk_err_d  = !dec_hit_p0;
        end

        // Registered ready: the next-cycle value depends only on SK occupancy.
        in_rdy_d = !sk_vld_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_vld_q  <= 1'b0;
            out_addr_q <= '0;
            out_idx_q  <= '0;
            out_err_q  <= 1'b0;
            sk_vld_q   <= 1'b0;
            sk_addr_q  <= '0;
            sk_idx_q   <= '0;
            sk_err_q   <= 1'b0;
            in_rdy_q   <= 1'b0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_addr_q <= out_addr_d;
            out_idx_q  <= out_idx_d;
            out_err_q  <= out_err_d;
            sk_vld_q   <= sk_vld_d;
            sk_addr_q  <= sk_addr_d;
            sk_idx_q   <= sk_idx_d;
            sk_err_q   <= sk_err_d;
            in_rdy_q   <= in_rdy_d;
        end
    end

    assign in_ready_o  = in_rdy_q;
    assign out_valid_o = out_vld_q;
    assign out_addr_o  = out_addr_q;
    assign out_idx_o   = out_idx_q;
    assign out_err_o   = out_err_q;

`ifdef ADDR_MAP_DECODE_MISS_STATS_EN
    // ---- miss statistics, updated at input acceptance ----
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] miss_cnt_q,  miss_cnt_d;
    logic [31:0] last_miss_q, last_miss_d;

    always_comb begin
        miss_cnt_d  = miss_cnt_q;
        last_miss_d = last_miss_q;
        if (in_xfer && !dec_hit_p0) begin
            miss_cnt_d  = sat_inc16(miss_cnt_q);
            last_miss_d = in_addr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            miss_cnt_q  <= '0;
            last_miss_q <= '0;
        end else begin
            miss_cnt_q  <= miss_cnt_d;
            last_miss_q <= last_miss_d;
        end
    end

    assign miss_cnt_o       = miss_cnt_q;
    assign last_miss_addr_o = last_miss_q;
`else
    assign miss_cnt_o       = 16'd0;
    assign last_miss_addr_o = 32'd0;
`endif

endmodule

// File: tb/tb_addr_map_decode_pipe.sv
module tb_addr_map_decode_pipe;
    import addr_map_rule_pkg::*;

    logic                      clk;
    logic                      rst_n;
    addr_map_rule_t [3:0]      addr_map;
    logic                      in_valid;
    logic                      in_ready;
    logic [31:0]               in_addr;
    logic                      out_valid;
    logic                      out_ready;
    logic [31:0]               out_addr;
    logic [31:0]               out_idx;
    logic                      out_err;
    logic [15:0]               miss_cnt;
    logic [31:0]               last_miss;

    int total = 0;
    int bad   = 0;

    addr_map_decode_pipe #(.NUM_RULES(4), .DEFAULT_IDX(32'd0)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .addr_map_i       (addr_map),
        .in_valid_i       (in_valid),
        .in_ready_o       (in_ready),
        .in_addr_i        (in_addr),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready),
        .out_addr_o       (out_addr),
        .out_idx_o        (out_idx),
        .out_err_o        (out_err),
        .miss_cnt_o       (miss_cnt),
        .last_miss_addr_o (last_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // map 0: basic/boundary map; map 1: overlap map with degenerate rules
    task automatic set_map(input logic sel);
        if (!sel) begin
            addr_map[0] = '{idx: 32'd0, start_addr: 32'h0000_0000, end_addr: 32'h0001_0000};
            addr_map[1] = '{idx: 32'd1, start_addr: 32'h0001_0000, end_addr: 32'h0002_0000};
            addr_map[2] = '{idx: 32'd5, start_addr: 32'h2000_0000, end_addr: 32'h2000_1000};
            addr_map[3] = '{idx: 32'd3, start_addr: 32'h3000_0000, end_addr: 32'h3000_0000};
        end else begin
            addr_map[0] = '{idx: 32'd7, start_addr: 32'h0000_0100, end_addr: 32'h0000_0200};
            addr_map[1] = '{idx: 32'd9, start_addr: 32'h0000_0180, end_addr: 32'h0000_0300};
            addr_map[2] = '{idx: 32'd4, start_addr: 32'h0000_0500, end_addr: 32'h0000_0400};
            addr_map[3] = '{idx: 32'd2, start_addr: 32'h0000_0000, end_addr: 32'h0000_0000};
        end
    endtask

    typedef struct {
        logic        sel;
        logic [31:0] addr;
        logic [31:0] idx;
        logic        err;
    } vec_t;

    vec_t vecs[14];

    logic [31:0] bp_addr[4];
    logic [31:0] bp_idx[4];
    logic        bp_err[4];
    int          rec_cyc[4];

    initial begin
        vecs[0]  = '{1'b0, 32'h0001_0004, 32'd1, 1'b0};
        vecs[1]  = '{1'b0, 32'h2000_0FFC, 32'd5, 1'b0};
        vecs[2]  = '{1'b0, 32'h0001_0000, 32'd1, 1'b0};
        vecs[3]  = '{1'b0, 32'h2000_1000, 32'd0, 1'b1};
        vecs[4]  = '{1'b0, 32'h3000_0000, 32'd0, 1'b1};
        vecs[5]  = '{1'b0, 32'h0000_FFFF, 32'd0, 1'b0};
        vecs[6]  = '{1'b0, 32'h0001_FFFF, 32'd1, 1'b0};
        vecs[7]  = '{1'b1, 32'h0000_01C0, 32'd7, 1'b0};
        vecs[8]  = '{1'b1, 32'h0000_0180, 32'd7, 1'b0};
        vecs[9]  = '{1'b1, 32'h0000_0200, 32'd9, 1'b0};
        vecs[10] = '{1'b1, 32'h0000_02FF, 32'd9, 1'b0};
        vecs[11] = '{1'b1, 32'h0000_0300, 32'd0, 1'b1};
        vecs[12] = '{1'b1, 32'h0000_00FF, 32'd0, 1'b1};
        vecs[13] = '{1'b1, 32'h0000_0450, 32'd0, 1'b1};

        bp_addr[0] = 32'h0001_0010; bp_idx[0] = 32'd1; bp_err[0] = 1'b0;
        bp_addr[1] = 32'h2000_0010; bp_idx[1] = 32'd5; bp_err[1] = 1'b0;
        bp_addr[2] = 32'h0000_0020; bp_idx[2] = 32'd0; bp_err[2] = 1'b0;
        bp_addr[3] = 32'h4000_0000; bp_idx[3] = 32'd0; bp_err[3] = 1'b1;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_addr   = '0;
        out_ready = 1'b1;
        set_map(1'b0);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_addr", out_addr, 32'd0);
        chk("rst_out_idx", out_idx, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        chk("rst_miss_cnt", {16'd0, miss_cnt}, 32'd0);
        chk("rst_last_miss", last_miss, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // table-driven single decodes, out_ready held high
        for (int v = 0; v < 14; v++) begin
            @(negedge clk);
            set_map(vecs[v].sel);
            in_valid = 1'b1;
            in_addr  = vecs[v].addr;
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", v), {31'd0, out_valid}, 32'd1);
            chk($sformatf("vec%0d_addr", v), out_addr, vecs[v].addr);
            chk($sformatf("vec%0d_idx", v), out_idx, vecs[v].idx);
            chk($sformatf("vec%0d_err", v), {31'd0, out_err}, {31'd0, vecs[v].err});
        end
        @(negedge clk);
        chk("drain_empty", {31'd0, out_valid}, 32'd0);

        // decode result is fixed at acceptance time
        set_map(1'b0);
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_addr  = 32'h0001_0004;
        @(negedge clk);
        in_valid = 1'b0;
        addr_map[1].idx = 32'd8;
        @(negedge clk);
        chk("hold_map_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_map_idx", out_idx, 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("hold_map_drained", {31'd0, out_valid}, 32'd0);
        set_map(1'b0);

        // backpressure: 4 back-to-back requests while the consumer stalls
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    int guard;
                    @(negedge clk);
                    in_valid = 1'b1;
                    in_addr  = bp_addr[i];
                    guard = 0;
                    while (!in_ready && guard < 50) begin
                        @(negedge clk);
                        guard++;
                    end
                    if (guard >= 50) chk("bp_producer_timeout", 32'd1, 32'd0);
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin
                int got;
                int cyc;
                repeat (3) @(negedge clk);
                chk("bp_stall_valid", {31'd0, out_valid}, 32'd1);
                chk("bp_stall_addr", out_addr, bp_addr[0]);
                chk("bp_stall_ready", {31'd0, in_ready}, 32'd0);
                @(negedge clk);
                chk("bp_stable_addr", out_addr, bp_addr[0]);
                chk("bp_stable_idx", out_idx, bp_idx[0]);
                chk("bp_stable_ready", {31'd0, in_ready}, 32'd0);
                out_ready = 1'b1;
                got = 0;
                cyc = 0;
                while (got < 4 && cyc < 40) begin
                    if (out_valid) begin
                        chk($sformatf("bp_out%0d_addr", got), out_addr, bp_addr[got]);
                        chk($sformatf("bp_out%0d_idx", got), out_idx, bp_idx[got]);
                        chk($sformatf("bp_out%0d_err", got), {31'd0, out_err}, {31'd0, bp_err[got]});
                        rec_cyc[got] = cyc;
                        got++;
                    end
                    @(negedge clk);
                    cyc++;
                end
                chk("bp_count", got, 32'd4);
                if (got == 4) chk("bp_rate", rec_cyc[3] - rec_cyc[0], 32'd3);
                chk("bp_after_empty", {31'd0, out_valid}, 32'd0);
            end
        join

        // asynchronous reset with both slots full
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_addr  = 32'h0001_0100;
        @(negedge clk);
        in_addr  = 32'h0001_0200;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_full_valid", {31'd0, out_valid}, 32'd1);
        chk("mid_full_ready", {31'd0, in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_post_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_post_valid", {31'd0, out_valid}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_no_stale", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        in_valid = 1'b1;
        in_addr  = 32'h2000_0004;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_resume_addr", out_addr, 32'h2000_0004);
        chk("mid_resume_idx", out_idx, 32'd5);

`ifdef ADDR_MAP_DECODE_MISS_STATS_EN
        // counter restarts from reset, then three isolated misses
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_addr  = 32'h4000_0000 + 32'(i * 4);
            @(negedge clk);
            in_valid = 1'b0;
        end
        chk("miss_cnt3", {16'd0, miss_cnt}, 32'd3);
        chk("miss_last3", last_miss, 32'h4000_0008);
        @(negedge clk);
        in_valid = 1'b1;
        in_addr  = 32'h5000_0000;
        repeat (65540) @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("miss_cnt_sat", {16'd0, miss_cnt}, 32'h0000_FFFF);
        chk("miss_last_sat", last_miss, 32'h5000_0000);
`else
        chk("miss_cnt_off", {16'd0, miss_cnt}, 32'd0);
        chk("miss_last_off", last_miss, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
